ninjin_ddr_pack: RTL and testbench

Write-side burst packer between the kinpira output stream and the ninjin DDR master. It accepts DWIDTH-bit result words from kinpira, packs pairs into BWIDTH-bit DDR beats and buffers them in two ping-pong banks. It issues one address request plus a data burst per filled bank, or per partial bank on flush. The DDR master consumes these requests and beats and drives the external memory.

---
 rtl/ninjin_ddr_pack_pkg.sv | 14 +
 rtl/ninjin_ddr_pack_bank.sv | 37 +++
 rtl/ninjin_ddr_pack.sv | 196 +++++++++++++++++++
 tb/tb_ninjin_ddr_pack.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ninjin_ddr_pack_pkg.sv
// Shared widths and drain state encoding for the ninjin write-side burst packer.
package ninjin_ddr_pack_pkg;

  localparam int unsigned DWIDTH    = 16;
  localparam int unsigned BWIDTH    = 2 * DWIDTH;
  localparam int unsigned BURST_MAX = 16;

  typedef enum logic [1:0] {
    D_IDLE,
    D_REQ,
    D_DATA
  } drain_state_e;

endpackage

// File: rtl/ninjin_ddr_pack_bank.sv
// Ping-pong beat buffer: simple dual-port RAM, one write port, one registered read port.
// The address MSB selects the bank.
module ninjin_ddr_pack_bank #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value while re_i is low, so the beat stays stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ninjin_ddr_pack.sv
// Packs kinpira result words into DDR beats, buffers them in two banks and drains each bank
// as one address request plus a data burst.
module ninjin_ddr_pack
  import ninjin_ddr_pack_pkg::*;
(
  input  logic              clk_i,
  input  logic              xrst_ni,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [31:0]       req_addr_o,
  output logic [7:0]        req_len_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [BWIDTH-1:0] wdata_o,
  output logic              wlast_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned IdxW = $clog2(BURST_MAX);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(BURST_MAX);

  // Packer state
  logic              busy_q, last_seen_q, fill_bank_q, half_q;
  logic [DWIDTH-1:0] stage_q;
  logic [CntW-1:0]   beat_cnt_q;
  logic [1:0]        bank_ready_q, bank_ready_d, bank_last_q;
  logic [CntW-1:0]   bank_len_q [2];

  // Drain state
  drain_state_e      state_q;
  logic              drain_bank_q;
  logic [CntW-1:0]   rd_idx_q;
  logic [31:0]       ptr_q, req_addr_q;
  logic [7:0]        req_len_q;
  logic              req_valid_q, wvalid_q, wlast_q, done_q;

  logic              start_ok, in_ready, in_fire, we, fill_done, ren, w_fire, rel;
  logic [CntW-1:0]   beat_cnt_inc;
  logic [BWIDTH-1:0] wbeat;

  always_comb begin
    start_ok     = start_i & ~busy_q;
    in_ready     = busy_q & ~last_seen_q & ~bank_ready_q[fill_bank_q];
    in_fire      = in_valid_i & in_ready;
    we           = in_fire & (half_q | in_last_i);
    wbeat        = half_q ? {in_data_i, stage_q} : {{DWIDTH{1'b0}}, in_data_i};
    beat_cnt_inc = beat_cnt_q + CntW'(1);
    fill_done    = we & ((beat_cnt_inc == FullCnt) | in_last_i);
    ren          = (state_q == D_DATA) & (8'(rd_idx_q) <= req_len_q) & (~wvalid_q | wready_i);
    w_fire       = wvalid_q & wready_i;
    rel          = w_fire & wlast_q;
  end

  // Fill and release never target the same bank: a ready bank is never the fill bank.
  always_comb begin
    bank_ready_d = bank_ready_q;
    if (fill_done) bank_ready_d[fill_bank_q] = 1'b1;
    if (rel)       bank_ready_d[drain_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge xrst_ni) begin
    if (!xrst_ni) begin
      busy_q        <= 1'b0;
      last_seen_q   <= 1'b0;
      fill_bank_q   <= 1'b0;
      half_q        <= 1'b0;
      stage_q       <= '0;
      beat_cnt_q    <= '0;
      bank_ready_q  <= '0;
      bank_last_q   <= '0;
      bank_len_q[0] <= '0;
      bank_len_q[1] <= '0;
    end else begin
      bank_ready_q <= bank_ready_d;
      if (start_ok) begin
        busy_q      <= 1'b1;
        last_seen_q <= 1'b0;
        fill_bank_q <= 1'b0;
        half_q      <= 1'b0;
        beat_cnt_q  <= '0;
      end else if (in_fire) begin
        if (in_last_i) last_seen_q <= 1'b1;
        if (!half_q && !in_last_i) begin
          stage_q <= in_data_i;
          half_q  <= 1'b1;
        end else begin
          half_q <= 1'b0;
        end
        if (fill_done) begin
          beat_cnt_q               <= '0;
          fill_bank_q              <= ~fill_bank_q;
          bank_len_q[fill_bank_q]  <= beat_cnt_inc;
          bank_last_q[fill_bank_q] <= in_last_i;
        end else if (we) begin
          beat_cnt_q <= beat_cnt_inc;
        end
      end
      if (rel && bank_last_q[drain_bank_q]) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge xrst_ni) begin
    if (!xrst_ni) begin
      state_q      <= D_IDLE;
      drain_bank_q <= 1'b0;
      rd_idx_q     <= '0;
      ptr_q        <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_len_q    <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        ptr_q        <= base_addr_i;
        drain_bank_q <= 1'b0;
      end
      // RAM read lags by one cycle, so the beat registers advance together with the read.
      if (ren) begin
        rd_idx_q <= rd_idx_q + CntW'(1);
        wvalid_q <= 1'b1;
        wlast_q  <= (8'(rd_idx_q) == req_len_q);
      end else if (w_fire) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end
      unique case (state_q)
        D_IDLE: begin
          if (bank_ready_q[drain_bank_q]) begin
            state_q     <= D_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= ptr_q;
            req_len_q   <= 8'(bank_len_q[drain_bank_q]) - 8'd1;
          end
        end
        D_REQ: begin
          if (req_ready_i) begin
            state_q     <= D_DATA;
            req_valid_q <= 1'b0;
            rd_idx_q    <= '0;
            ptr_q       <= ptr_q + ((32'(req_len_q) + 32'd1) << 2);
          end
        end
        D_DATA: begin
          if (rel) begin
            drain_bank_q <= ~drain_bank_q;
            done_q       <= bank_last_q[drain_bank_q];
            if (bank_ready_q[~drain_bank_q]) begin
              state_q     <= D_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= ptr_q;
              req_len_q   <= 8'(bank_len_q[~drain_bank_q]) - 8'd1;
            end else begin
              state_q <= D_IDLE;
            end
          end
        end
        default: state_q <= D_IDLE;
      endcase
    end
  end

  ninjin_ddr_pack_bank #(
    .Width(BWIDTH),
    .Depth(2 * BURST_MAX)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_ni (xrst_ni),
    .we_i   (we),
    .waddr_i({fill_bank_q, beat_cnt_q[IdxW-1:0]}),
    .wdata_i(wbeat),
    .re_i   (ren),
    .raddr_i({drain_bank_q, rd_idx_q[IdxW-1:0]}),
    .rdata_o(wdata_o)
  );

  assign in_ready_o  = in_ready;
  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_addr_q;
  assign req_len_o   = req_len_q;
  assign wvalid_o    = wvalid_q;
  assign wlast_o     = wlast_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ninjin_ddr_pack.sv
// Randomized stream bench for ninjin_ddr_pack against a burst-list reference model.
module tb_ninjin_ddr_pack;
  import ninjin_ddr_pack_pkg::*;

  logic              clk = 1'b0;
  logic              xrst_n;
  logic              start;
  logic [31:0]       base_addr;
  logic              in_valid, in_ready, in_last;
  logic [DWIDTH-1:0] in_data;
  logic              req_valid, req_ready;
  logic [31:0]       req_addr;
  logic [7:0]        req_len;
  logic              wvalid, wready, wlast, busy, done;
  logic [BWIDTH-1:0] wdata;

  always #5 clk = ~clk;

  ninjin_ddr_pack u_dut (
    .clk_i      (clk),
    .xrst_ni    (xrst_n),
    .start_i    (start),
    .base_addr_i(base_addr),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_addr_o (req_addr),
    .req_len_o  (req_len),
    .wvalid_o   (wvalid),
    .wready_i   (wready),
    .wdata_o    (wdata),
    .wlast_o    (wlast),
    .busy_o     (busy),
    .done_o     (done)
  );

  int total = 0;
  int bad   = 0;

  logic [DWIDTH-1:0] words[$];
  logic [31:0]       q_addr[$];
  logic [7:0]        q_len[$];
  logic [BWIDTH-1:0] q_beat[$];
  logic              q_wlast[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected beats are word pairs (odd word high, zero pad on an odd count), cut into
  // BURST_MAX-beat bursts at consecutive addresses.
  task automatic build_model(input logic [31:0] base);
    int n  = words.size();
    int nb = (n + 1) / 2;
    q_addr.delete(); q_len.delete(); q_beat.delete(); q_wlast.delete();
    for (int b = 0; b < nb; b++) begin
      logic [DWIDTH-1:0] lo = words[2*b];
      logic [DWIDTH-1:0] hi = (2*b + 1 < n) ? words[2*b+1] : '0;
      q_beat.push_back({hi, lo});
      q_wlast.push_back((b % BURST_MAX == BURST_MAX - 1) || (b == nb - 1));
    end
    for (int k = 0; k * BURST_MAX < nb; k++) begin
      int beats = (nb - k * BURST_MAX > BURST_MAX) ? BURST_MAX : nb - k * BURST_MAX;
      q_addr.push_back(base + 32'(k * BURST_MAX * 4));
      q_len.push_back(8'(beats - 1));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctrl"}, {58'd0, in_ready, req_valid, wvalid, wlast, busy, done}, 64'd0);
    chk({tag, "_req"}, {24'd0, req_addr, req_len}, 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  // wmode: 0 wready=1, 1 toggle, 2 random. stall_exp: 0 never, 1 must, 2 don't care.
  task automatic run_stream(input logic [31:0] base, input int wmode, input int rdelay,
                            input bit vrand, input int stall_exp, input bit inj_start,
                            input bit abort_wv);
    int n = words.size();
    int idx = 0, cyc = 0, rwait = 0, stalls = 0, extra_req = 0, extra_beat = 0;
    bit done_seen = 0, togg = 0;
    build_model(base);
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom;
    while (!done_seen && cyc < 6000) begin
      in_valid = (idx < n) && (!vrand || $urandom_range(0, 3) != 0);
      in_data  = (idx < n) ? words[idx] : DWIDTH'($urandom);
      in_last  = (idx == n - 1);
      wready   = (wmode == 0) ? 1'b1 : (wmode == 1) ? togg : 1'($urandom_range(0, 1));
      togg     = ~togg;
      rwait    = req_valid ? rwait + 1 : 0;
      req_ready = (rwait > rdelay);
      if (inj_start && cyc == 20) begin
        start = 1'b1; base_addr = 32'h2000;
      end else begin
        start = 1'b0;
      end
      #1;
      if (busy && !in_ready && idx < n) stalls++;
      if (in_valid && in_ready) idx++;
      if (req_valid && req_ready) begin
        if (q_addr.size() > 0) begin
          chk("req_addr", req_addr, q_addr.pop_front());
          chk("req_len", req_len, q_len.pop_front());
        end else extra_req++;
      end
      if (wvalid && wready) begin
        if (q_beat.size() > 0) begin
          chk("wdata", wdata, q_beat.pop_front());
          chk("wlast", wlast, q_wlast.pop_front());
        end else extra_beat++;
      end
      if (done) done_seen = 1;
      if (abort_wv && wvalid) break;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_wv) begin
      chk("abort_reached_data", wvalid, 1'b1);
      return;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("done_seen", done_seen, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("in_ready_at_done", in_ready, 1'b0);
    chk("words_used", idx, n);
    chk("extra_req", extra_req, 0);
    chk("extra_beat", extra_beat, 0);
    chk("reqs_left", q_addr.size(), 0);
    chk("beats_left", q_beat.size(), 0);
    if (stall_exp == 0) chk("no_stall", stalls, 0);
    if (stall_exp == 1) chk("stalled", stalls > 0, 1'b1);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic fill_seq(input int n, input logic [DWIDTH-1:0] first);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(first + DWIDTH'(i));
  endtask

  task automatic fill_rand(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(DWIDTH'($urandom));
  endtask

  initial begin
    xrst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; req_ready = 1'b0; wready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outs("reset");
    @(negedge clk);
    xrst_n = 1'b1;

    // Full stream at full rate: two 16-beat bursts, no input stall.
    fill_seq(64, 16'h0001);
    run_stream(32'h1000, 0, 0, 0, 0, 0, 0);

    // Odd flush: five words -> three beats, last one zero-padded.
    fill_seq(5, 16'h000A);
    run_stream(32'h0400, 0, 0, 1, 2, 0, 0);

    // Single word stream.
    fill_seq(1, 16'hBEEF);
    run_stream(32'h0800, 2, 1, 0, 2, 0, 0);

    // Backpressure: both banks fill up, sequence must be unaffected.
    fill_rand(96);
    run_stream(32'h4000, 1, 5, 0, 1, 0, 0);

    // Exact fill: one full bank with the last word, no empty trailing burst.
    fill_seq(32, 16'h0100);
    run_stream(32'h0C00, 0, 0, 0, 0, 0, 0);

    // Start while busy is ignored.
    fill_rand(40);
    run_stream(32'h3000, 2, 2, 1, 2, 1, 0);

    // Reset in the middle of a data burst, then a fresh stream at base 0.
    fill_rand(40);
    run_stream(32'h0500, 0, 0, 0, 2, 0, 1);
    xrst_n = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    xrst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("no_done_after_reset", {busy, done}, 2'b00);
    fill_rand(10);
    run_stream(32'h0000_0000, 0, 0, 0, 2, 0, 0);

    // Randomized streams.
    for (int t = 0; t < 6; t++) begin
      fill_rand($urandom_range(1, 80));
      run_stream($urandom & 32'hFFFF_FFFC, $urandom_range(0, 2), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 2, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
